// File: rtl/led_matrix_pkg.sv
// rtl/led_matrix_pkg.sv - shared geometry and helpers for the LED matrix scanner
package led_matrix_pkg;

    localparam int N_ROWS = 6;
    localparam int N_COLS = 6;
    localparam int IMG_W  = N_ROWS * N_COLS;

    typedef logic [2:0] row_idx_t;

    function automatic logic [N_ROWS-1:0] row_onehot(input row_idx_t idx);
        return N_ROWS'(1) << idx;
    endfunction

    // Lines are computed active-high internally and flipped only at the pins.
    function automatic logic [5:0] apply_pol(input logic [5:0] v, input logic active_low);
        return active_low ? ~v : v;
    endfunction

endpackage

// File: rtl/led_matrix_scan_if.sv
// rtl/led_matrix_scan_if.sv - image in / row+column drive bundle
interface led_matrix_scan_if;
    import led_matrix_pkg::*;

    logic [IMG_W-1:0]  img;
    logic [N_ROWS-1:0] row;
    logic [N_COLS-1:0] col;

    modport master (output img, input row, input col);
    modport slave  (input img, output row, output col);

endinterface

// File: rtl/led_matrix_tick.sv
// rtl/led_matrix_tick.sv - modulo slot counter with end-of-slot pulse
module led_matrix_tick #(
    parameter int MOD = 2000,
    parameter int CW  = $clog2(MOD)
) (
    input  logic          clk,
    input  logic          rst,
    output logic [CW-1:0] o_cnt,
    output logic          o_slot_end
);

    logic [CW-1:0] r_cnt;

    assign o_slot_end = (r_cnt == CW'(MOD - 1));
    assign o_cnt      = r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (o_slot_end) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/led_matrix_scan.sv
// rtl/led_matrix_scan.sv - row-at-a-time scanner for a 6x6 LED matrix with blanking gap
module led_matrix_scan
    import led_matrix_pkg::*;
#(
    parameter int ROW_CYCLES     = 2000,
    parameter int BLANK_CYCLES   = 24,
    parameter int ROW_ACTIVE_LOW = 0,
    parameter int COL_ACTIVE_LOW = 1
) (
    input  logic              clk,
    input  logic              rst,
    led_matrix_scan_if.slave  bus
);

    localparam int   CW     = $clog2(ROW_CYCLES);
    localparam logic ROW_AL = (ROW_ACTIVE_LOW != 0);
    localparam logic COL_AL = (COL_ACTIVE_LOW != 0);

    logic [CW-1:0]     w_cnt;
    logic              w_slot_end;
    logic              w_blank;
    logic [5:0]        w_base;
    row_idx_t          r_ridx;
    logic [N_COLS-1:0] r_img_lat;
    logic [N_ROWS-1:0] r_row;
    logic [N_COLS-1:0] r_col;

    led_matrix_tick #(
        .MOD (ROW_CYCLES),
        .CW  (CW)
    ) u_tick (
        .clk        (clk),
        .rst        (rst),
        .o_cnt      (w_cnt),
        .o_slot_end (w_slot_end)
    );

    assign w_blank = (w_cnt < CW'(BLANK_CYCLES));
    assign w_base  = 6'(r_ridx) * 6'(N_COLS);

    // The slice is frozen at slot start so a mid-slot image write cannot tear the row.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ridx    <= '0;
            r_img_lat <= '0;
            r_row     <= apply_pol(6'h00, ROW_AL);
            r_col     <= apply_pol(6'h00, COL_AL);
        end else begin
            if (w_slot_end) begin
                r_ridx <= (r_ridx == row_idx_t'(N_ROWS - 1)) ? '0 : r_ridx + row_idx_t'(1);
            end
            if (w_cnt == '0) begin
                r_img_lat <= bus.img[w_base +: N_COLS];
            end
            if (w_blank) begin
                r_row <= apply_pol(6'h00, ROW_AL);
                r_col <= apply_pol(6'h00, COL_AL);
            end else begin
                r_row <= apply_pol(row_onehot(r_ridx), ROW_AL);
                r_col <= apply_pol(r_img_lat, COL_AL);
            end
        end
    end

    assign bus.row = r_row;
    assign bus.col = r_col;

endmodule

// File: tb/tb_led_matrix_scan.sv
// tb/tb_led_matrix_scan.sv - randomized self-checking bench for led_matrix_scan
module tb_led_matrix_scan;

    localparam int RC = 8;
    localparam int BC = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    led_matrix_scan_if dif();
    led_matrix_scan_if pif();

    led_matrix_scan #(.ROW_CYCLES(RC), .BLANK_CYCLES(BC), .ROW_ACTIVE_LOW(0), .COL_ACTIVE_LOW(1))
        dut (.clk(clk), .rst(rst), .bus(dif));
    led_matrix_scan #(.ROW_CYCLES(RC), .BLANK_CYCLES(BC), .ROW_ACTIVE_LOW(1), .COL_ACTIVE_LOW(0))
        dut_pol (.clk(clk), .rst(rst), .bus(pif));

    int n_checks = 0;
    int n_fail   = 0;
    logic [35:0] diag;

    // Reference: count unreset edges; the slice of each slot is whatever img held at its first edge.
    int ek = 0;
    logic [5:0] snap = 6'h00;
    always @(posedge clk) begin
        if (rst) begin
            ek <= 0;
        end else begin
            if (ek % RC == 0) snap <= dif.img[6*((ek/RC)%6) +: 6];
            ek <= ek + 1;
        end
    end

    function automatic bit m_active(int e);
        return (e > 0) && (((e - 1) % RC) >= BC);
    endfunction

    function automatic logic [5:0] m_row(int e);
        if (!m_active(e)) return 6'h00;
        return 6'(1 << (((e - 1) / RC) % 6));
    endfunction

    function automatic logic [5:0] m_col(int e, logic [5:0] s);
        if (!m_active(e)) return 6'h3F;
        return ~s;
    endfunction

    task automatic test_reset;
        int lat;
        for (int r = 0; r < 6; r++) diag[6*r +: 6] = 6'(1 << r);
        dif.img = diag;
        pif.img = '1;
        rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            n_checks += 4;
            if (dif.row !== 6'h00) begin n_fail++; $display("FAIL reset_row: got %b expected %b", dif.row, 6'h00); end
            if (dif.col !== 6'h3F) begin n_fail++; $display("FAIL reset_col: got %b expected %b", dif.col, 6'h3F); end
            if (pif.row !== 6'h3F) begin n_fail++; $display("FAIL reset_prow: got %b expected %b", pif.row, 6'h3F); end
            if (pif.col !== 6'h00) begin n_fail++; $display("FAIL reset_pcol: got %b expected %b", pif.col, 6'h00); end
        end
        rst = 1'b0;
        lat = 0;
        for (int i = 1; i <= 20 && lat == 0; i++) begin
            @(negedge clk);
            if (dif.row === 6'b000001) lat = i;
        end
        n_checks++;
        if (lat != BC + 1) begin n_fail++; $display("FAIL first_row_latency: got %0d expected %0d", lat, BC + 1); end
    endtask

    task automatic test_diagonal;
        for (int i = 0; i < 2 * 6 * RC; i++) begin
            @(negedge clk);
            n_checks += 3;
            if (dif.row !== m_row(ek)) begin n_fail++; $display("FAIL diag_row: got %b expected %b", dif.row, m_row(ek)); end
            if (dif.col !== m_col(ek, snap)) begin n_fail++; $display("FAIL diag_col: got %b expected %b", dif.col, m_col(ek, snap)); end
            if ($countones(dif.row) > 1) begin n_fail++; $display("FAIL diag_onehot: got %b expected at most one bit", dif.row); end
            if (m_active(ek) && ((ek - 1) / RC) % 6 == 2) begin
                n_checks += 2;
                if (dif.row !== 6'b000100) begin n_fail++; $display("FAIL diag_slot2_row: got %b expected %b", dif.row, 6'b000100); end
                if (dif.col !== 6'b111011) begin n_fail++; $display("FAIL diag_slot2_col: got %b expected %b", dif.col, 6'b111011); end
            end
        end
    endtask

    task automatic test_blanking;
        int blanks = 0;
        for (int i = 0; i < 6 * RC; i++) begin
            @(negedge clk);
            if (dif.row === 6'h00 && dif.col === 6'h3F) blanks++;
            n_checks++;
            if ($countones(dif.row) > 1) begin n_fail++; $display("FAIL blank_onehot: got %b expected at most one bit", dif.row); end
        end
        n_checks++;
        if (blanks != 6 * BC) begin n_fail++; $display("FAIL blank_count: got %0d expected %0d", blanks, 6 * BC); end
    endtask

    task automatic test_polarity;
        logic [5:0] er, ec;
        for (int i = 0; i < 6 * RC; i++) begin
            @(negedge clk);
            er = m_active(ek) ? ~m_row(ek) : 6'h3F;
            ec = m_active(ek) ? 6'h3F : 6'h00;
            n_checks += 2;
            if (pif.row !== er) begin n_fail++; $display("FAIL pol_row: got %b expected %b", pif.row, er); end
            if (pif.col !== ec) begin n_fail++; $display("FAIL pol_col: got %b expected %b", pif.col, ec); end
        end
    endtask

    task automatic test_midslot;
        logic [5:0] prev;
        bit found = 0;
        int drive = 0;
        prev = dif.row;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            if (dif.row === 6'b001000 && prev !== 6'b001000) found = 1;
            prev = dif.row;
        end
        n_checks++;
        if (!found) begin n_fail++; $display("FAIL mid_find_row3: got timeout expected row3"); end
        dif.img = ~diag;
        while (dif.row === 6'b001000 && drive < 20) begin
            drive++;
            n_checks++;
            if (dif.col !== 6'b110111) begin n_fail++; $display("FAIL mid_row3_col: got %b expected %b", dif.col, 6'b110111); end
            @(negedge clk);
        end
        n_checks++;
        if (drive != RC - BC) begin n_fail++; $display("FAIL mid_row3_len: got %0d expected %0d", drive, RC - BC); end
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (dif.row === 6'b010000) found = 1;
            else @(negedge clk);
        end
        n_checks += 2;
        if (!found) begin n_fail++; $display("FAIL mid_find_row4: got timeout expected row4"); end
        if (dif.col !== 6'b010000) begin n_fail++; $display("FAIL mid_row4_col: got %b expected %b", dif.col, 6'b010000); end
    endtask

    task automatic test_random;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            n_checks += 2;
            if (dif.row !== m_row(ek)) begin n_fail++; $display("FAIL rand_row: got %b expected %b", dif.row, m_row(ek)); end
            if (dif.col !== m_col(ek, snap)) begin n_fail++; $display("FAIL rand_col: got %b expected %b", dif.col, m_col(ek, snap)); end
            if ($urandom_range(0, 7) == 0) dif.img = {4'($urandom), 32'($urandom)};
        end
    endtask

    task automatic test_reset_mid;
        bit found = 0;
        int lat = 0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            if (dif.row === 6'b010000) found = 1;
        end
        n_checks++;
        if (!found) begin n_fail++; $display("FAIL rmid_find_row4: got timeout expected row4"); end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_checks += 2;
        if (dif.row !== 6'h00) begin n_fail++; $display("FAIL rmid_row: got %b expected %b", dif.row, 6'h00); end
        if (dif.col !== 6'h3F) begin n_fail++; $display("FAIL rmid_col: got %b expected %b", dif.col, 6'h3F); end
        rst = 1'b0;
        for (int i = 1; i <= 20 && lat == 0; i++) begin
            @(negedge clk);
            n_checks += 2;
            if (dif.row !== m_row(ek)) begin n_fail++; $display("FAIL rmid_scan_row: got %b expected %b", dif.row, m_row(ek)); end
            if (dif.col !== m_col(ek, snap)) begin n_fail++; $display("FAIL rmid_scan_col: got %b expected %b", dif.col, m_col(ek, snap)); end
            if (dif.row === 6'b000001) lat = i;
        end
        n_checks++;
        if (lat != BC + 1) begin n_fail++; $display("FAIL rmid_latency: got %0d expected %0d", lat, BC + 1); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        dif.img = '0;
        pif.img = '1;
        test_reset();
        test_diagonal();
        test_blanking();
        test_polarity();
        test_midslot();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
